// File: rtl/jtkunio_romarb.sv
// rtl/jtkunio_romarb.sv - three-way one-word ROM cache with round-robin SDRAM bank arbitration
module jtkunio_romarb #(
  parameter logic [21:0] MAIN_OFFSET = 22'h00_0000,
  parameter logic [21:0] SND_OFFSET  = 22'h00_8000,
  parameter logic [21:0] PCM_OFFSET  = 22'h00_C000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        downloading,
  input  logic        main_cs,
  input  logic [15:0] main_addr,
  output logic [7:0]  main_data,
  output logic        main_ok,
  input  logic        snd_cs,
  input  logic [14:0] snd_addr,
  output logic [7:0]  snd_data,
  output logic        snd_ok,
  input  logic        pcm_cs,
  input  logic [16:0] pcm_addr,
  output logic [7:0]  pcm_data,
  output logic        pcm_ok,
  output logic [21:0] ba_addr,
  output logic        ba_rd,
  input  logic        ba_ack,
  input  logic        ba_rdy,
  input  logic [15:0] data_read
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_t;

  state_t      r_state, w_next;
  logic [1:0]  r_sel, r_ptr;
  logic [15:0] r_tag_f;
  logic        r_discard;
  logic [21:0] r_ba_addr;
  logic        r_ba_rd;
  logic [2:0]  r_valid;
  logic [14:0] r_tag_main;
  logic [13:0] r_tag_snd;
  logic [15:0] r_tag_pcm;
  logic [15:0] r_word_main, r_word_snd, r_word_pcm;

  logic [2:0]  w_miss;
  logic [1:0]  w_p1, w_p2, w_win;
  logic [15:0] w_tag;
  logic [21:0] w_off;
  logic        w_grant, w_accept, w_fill;

  assign main_ok = main_cs & r_valid[0] & (r_tag_main == main_addr[15:1]);
  assign snd_ok  = snd_cs  & r_valid[1] & (r_tag_snd  == snd_addr[14:1]);
  assign pcm_ok  = pcm_cs  & r_valid[2] & (r_tag_pcm  == pcm_addr[16:1]);

  assign main_data = main_addr[0] ? r_word_main[15:8] : r_word_main[7:0];
  assign snd_data  = snd_addr[0]  ? r_word_snd[15:8]  : r_word_snd[7:0];
  assign pcm_data  = pcm_addr[0]  ? r_word_pcm[15:8]  : r_word_pcm[7:0];

  assign w_miss = {pcm_cs & ~pcm_ok, snd_cs & ~snd_ok, main_cs & ~main_ok} & {3{~downloading}};

  assign ba_addr = r_ba_addr;
  assign ba_rd   = r_ba_rd;

  // Round-robin: first missing requester at or after r_ptr, wrapping mod 3
  always_comb begin
    w_p1  = (r_ptr == 2'd2) ? 2'd0 : r_ptr + 2'd1;
    w_p2  = (w_p1  == 2'd2) ? 2'd0 : w_p1  + 2'd1;
    w_win = w_miss[r_ptr] ? r_ptr : (w_miss[w_p1] ? w_p1 : w_p2);
    case (w_win)
      2'd0:    begin w_tag = {1'b0, main_addr[15:1]}; w_off = MAIN_OFFSET; end
      2'd1:    begin w_tag = {2'b0, snd_addr[14:1]};  w_off = SND_OFFSET;  end
      default: begin w_tag = pcm_addr[16:1];          w_off = PCM_OFFSET;  end
    endcase
  end

  always_comb begin
    w_next   = r_state;
    w_grant  = 1'b0;
    w_accept = 1'b0;
    w_fill   = 1'b0;
    case (r_state)
      ST_IDLE: if (|w_miss) begin w_grant = 1'b1; w_next = ST_REQ; end
      ST_REQ:  if (ba_ack)  begin w_accept = 1'b1; w_next = ST_WAIT; end
      ST_WAIT: if (ba_rdy)  begin w_fill = 1'b1; w_next = ST_IDLE; end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel       <= 2'd0;
      r_ptr       <= 2'd0;
      r_tag_f     <= 16'd0;
      r_discard   <= 1'b0;
      r_ba_addr   <= 22'd0;
      r_ba_rd     <= 1'b0;
      r_valid     <= 3'b000;
      r_tag_main  <= 15'd0;
      r_tag_snd   <= 14'd0;
      r_tag_pcm   <= 16'd0;
      r_word_main <= 16'd0;
      r_word_snd  <= 16'd0;
      r_word_pcm  <= 16'd0;
    end else begin
      if (w_grant) begin
        r_sel     <= w_win;
        r_tag_f   <= w_tag;
        r_ba_addr <= w_off + {6'd0, w_tag};
        r_ba_rd   <= 1'b1;
        r_discard <= 1'b0;
      end
      if (w_accept) r_ba_rd <= 1'b0;
      // A download touching any part of a transaction poisons its data
      if (downloading && r_state != ST_IDLE) r_discard <= 1'b1;
      if (w_fill) begin
        r_ptr <= (r_sel == 2'd2) ? 2'd0 : r_sel + 2'd1;
        case (r_sel)
          2'd0:    begin r_word_main <= data_read; r_tag_main <= r_tag_f[14:0]; end
          2'd1:    begin r_word_snd  <= data_read; r_tag_snd  <= r_tag_f[13:0]; end
          default: begin r_word_pcm  <= data_read; r_tag_pcm  <= r_tag_f;       end
        endcase
      end
      if (downloading) r_valid <= 3'b000;
      else if (w_fill && !r_discard) begin
        case (r_sel)
          2'd0:    r_valid[0] <= 1'b1;
          2'd1:    r_valid[1] <= 1'b1;
          default: r_valid[2] <= 1'b1;
        endcase
      end
    end
  end

endmodule
